sin_freq_meter: RTL and testbench

//  Receive-side counterpart of the NCO sine path. Takes 8-bit offset-binary sine samples
//  (midscale 128, as produced by sinlt) and detects rising midscale crossings with

---
 rtl/nco_pkg.sv | 27 ++
 rtl/sin_freq_meter_if.sv | 25 ++
 rtl/sin_xing_det.sv | 51 +++++
 rtl/sin_freq_meter.sv | 97 +++++++++
 tb/tb_sin_freq_meter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/nco_pkg.sv
// rtl/nco_pkg.sv - shared types and constants for the NCO sine path
// Crossing-detector state and sample classes, plus the hysteresis classifier.
package nco_pkg;

  typedef enum logic [1:0] {SEEK, LOW, HIGH} xing_state_t;

  typedef enum logic [1:0] {CL_LO, CL_BAND, CL_HI} sample_class_t;

  localparam logic [7:0] MID_CODE = 8'd128;

  // 9-bit thresholds so mid +/- hyst cannot wrap inside the 8-bit code space
  function automatic sample_class_t classify(input logic [7:0] s,
                                             input logic [7:0] mid,
                                             input logic [7:0] hyst);
    logic [8:0] lo_th;
    logic [8:0] hi_th;
    lo_th = {1'b0, mid} - {1'b0, hyst};
    hi_th = {1'b0, mid} + {1'b0, hyst};
    if ({1'b0, s} < lo_th)
      return CL_LO;
    else if ({1'b0, s} >= hi_th)
      return CL_HI;
    else
      return CL_BAND;
  endfunction

endpackage

// File: rtl/sin_freq_meter_if.sv
// rtl/sin_freq_meter_if.sv - sample input and period result bundle
// The source of samples drives through master; the meter sits on slave.
interface sin_freq_meter_if #(
  parameter int CNT_W     = 16,
  parameter int LOG2_NPER = 2
);

  logic                         sample_valid;
  logic [7:0]                   sample;
  logic [CNT_W+LOG2_NPER-1:0]   period_sum;
  logic                         period_valid;
  logic                         locked;
  logic                         no_signal;

  modport master (
    output sample_valid, sample,
    input  period_sum, period_valid, locked, no_signal
  );

  modport slave (
    input  sample_valid, sample,
    output period_sum, period_valid, locked, no_signal
  );

endinterface

// File: rtl/sin_xing_det.sv
// rtl/sin_xing_det.sv - rising midscale crossing detector with hysteresis
// Emits a combinational strobe on the qualified sample that completes LOW->HIGH.
module sin_xing_det
  import nco_pkg::*;
#(
  parameter logic [7:0] MID  = MID_CODE,
  parameter logic [7:0] HYST = 8'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [7:0] sample,
  input  logic       clear,
  output logic       xing
);

  xing_state_t   state;
  xing_state_t   state_nxt;
  sample_class_t cls;

  assign cls = classify(sample, MID, HYST);

  always_ff @(posedge clk) begin
    if (rst)
      state <= SEEK;
    else
      state <= state_nxt;
  end

  // BAND samples fall through every arm and leave the state untouched
  always_comb begin
    state_nxt = state;
    xing      = 1'b0;
    if (sample_valid) begin
      unique case (state)
        SEEK: if (cls == CL_LO) state_nxt = LOW;
        LOW: begin
          if (cls == CL_HI) begin
            state_nxt = HIGH;
            xing      = 1'b1;
          end
        end
        HIGH: if (cls == CL_LO) state_nxt = LOW;
        default: state_nxt = SEEK;
      endcase
      if (clear && !xing)
        state_nxt = SEEK;
    end
  end

endmodule

// File: rtl/sin_freq_meter.sv
// rtl/sin_freq_meter.sv - sine period meter summing NPER crossing periods
// Times samples between rising crossings, sums NPER periods, and drops lock on timeout.
module sin_freq_meter
  import nco_pkg::*;
#(
  parameter int         CNT_W     = 16,
  parameter int         LOG2_NPER = 2,
  parameter logic [7:0] MID       = MID_CODE,
  parameter logic [7:0] HYST      = 8'd8
) (
  input logic             clk,
  input logic             rst,
  sin_freq_meter_if.slave bus
);

  localparam int                   SUM_W    = CNT_W + LOG2_NPER;
  localparam logic [CNT_W-1:0]     CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [LOG2_NPER-1:0] NPC_LAST = {LOG2_NPER{1'b1}};

  logic [CNT_W-1:0]     cnt;
  logic [SUM_W-1:0]     acc;
  logic [LOG2_NPER-1:0] npc;
  logic                 started;
  logic [SUM_W-1:0]     period_sum_q;
  logic                 period_valid_q;
  logic                 locked_q;
  logic                 no_signal_q;

  logic                 xing;
  logic                 timeout;
  logic [SUM_W-1:0]     this_period;

  sin_xing_det #(
    .MID  (MID),
    .HYST (HYST)
  ) u_det (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (bus.sample_valid),
    .sample       (bus.sample),
    .clear        (timeout),
    .xing         (xing)
  );

  assign this_period = SUM_W'(cnt) + SUM_W'(1'b1);
  // An edge on the last count still wins: its period is at most 2^CNT_W-1
  assign timeout     = bus.sample_valid && started && !xing && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      acc            <= '0;
      npc            <= '0;
      started        <= 1'b0;
      period_sum_q   <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      no_signal_q    <= 1'b1;
    end else begin
      period_valid_q <= 1'b0;
      if (bus.sample_valid) begin
        if (xing) begin
          cnt <= '0;
          if (!started) begin
            started <= 1'b1;
          end else begin
            npc <= npc + 1'b1;
            if (npc == NPC_LAST) begin
              period_sum_q   <= acc + this_period;
              acc            <= '0;
              period_valid_q <= 1'b1;
              locked_q       <= 1'b1;
              no_signal_q    <= 1'b0;
            end else begin
              acc <= acc + this_period;
            end
          end
        end else if (timeout) begin
          started     <= 1'b0;
          cnt         <= '0;
          acc         <= '0;
          npc         <= '0;
          locked_q    <= 1'b0;
          no_signal_q <= 1'b1;
        end else if (started) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign bus.period_sum   = period_sum_q;
  assign bus.period_valid = period_valid_q;
  assign bus.locked       = locked_q;
  assign bus.no_signal    = no_signal_q;

endmodule

// File: tb/tb_sin_freq_meter.sv
// tb/tb_sin_freq_meter.sv - self-checking bench for sin_freq_meter
// NCO-driven sine stimulus; expected sums queued at the completing edge sample.
module tb_sin_freq_meter;

  typedef struct {
    int    lo;
    int    hi;
    string tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sin_freq_meter_if #(.CNT_W(16), .LOG2_NPER(2)) bus ();

  sin_freq_meter #(
    .CNT_W     (16),
    .LOG2_NPER (2),
    .MID       (8'd128),
    .HYST      (8'd8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;
  exp_t   sb[$];

  int     n_results = 0;
  longint last_result_cyc = 0;
  int     running_total = 0;
  int     exp_lo = 0;
  int     exp_hi = 0;
  string  exp_tag = "none";

  // reference crossing model: 0 seek, 1 low, 2 high
  int     mstate = 0;
  bit     mstarted = 0;
  int     medges = 0;
  int     mcnt = 0;

  int     phase = 0;
  int     step_sz = 1;

  function automatic int sinlt(input int p);
    real v;
    int  r;
    v = 128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * p / 256.0);
    r = int'($floor(v + 0.5));
    if (r < 0) r = 0;
    if (r > 255) r = 255;
    return r;
  endfunction

  task automatic check(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    mstate   = 0;
    mstarted = 0;
    medges   = 0;
    mcnt     = 0;
  endtask

  task automatic model_sample(input int s);
    bit   lo;
    bit   hi;
    bit   xg;
    int   nstate;
    exp_t e;
    lo = (s < 120);
    hi = (s >= 136);
    xg = (mstate == 1) && hi;
    nstate = mstate;
    if (lo) nstate = 1;
    else if (hi && mstate == 1) nstate = 2;
    if (xg) begin
      mcnt = 0;
      if (!mstarted) begin
        mstarted = 1;
      end else begin
        medges++;
        if (medges % 4 == 0) begin
          e.lo = exp_lo; e.hi = exp_hi; e.tag = exp_tag;
          sb.push_back(e);
        end
      end
      mstate = nstate;
    end else if (mstarted && mcnt == 65534) begin
      model_reset();
    end else begin
      if (mstarted) mcnt++;
      mstate = nstate;
    end
  endtask

  task automatic step(input bit v, input int s, input bit r);
    exp_t e;
    bit   in_r;
    int   sum;
    rst              = r;
    bus.sample_valid = v;
    bus.sample       = 8'(s);
    if (r) begin
      model_reset();
      sb.delete();
    end else if (v) begin
      model_sample(s);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (bus.period_valid === 1'b1 || sb.size() > 0) begin
      check("period_valid_timing", longint'(bus.period_valid), (sb.size() > 0) ? 1 : 0);
      if (bus.period_valid === 1'b1 && sb.size() > 0) begin
        e    = sb.pop_front();
        sum  = int'(bus.period_sum);
        in_r = (sum >= e.lo) && (sum <= e.hi);
        checks++;
        assert (in_r === 1'b1) else begin
          failures++;
          $error("FAIL %s observed=%0d expected=%0d..%0d", e.tag, sum, e.lo, e.hi);
        end
        check("locked_after_result", longint'(bus.locked), 1);
        check("no_signal_after_result", longint'(bus.no_signal), 0);
        n_results++;
        last_result_cyc = cyc;
        running_total  += sum;
      end else begin
        sb.delete();
      end
    end
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, sinlt(phase), 1'b0);
      phase = (phase + step_sz) % 256;
    end
  endtask

  task automatic do_reset();
    step(1'b0, 0, 1'b1);
    phase = 0;
  endtask

  task automatic set_exp(input int lo, input int hi, input string tag);
    exp_lo  = lo;
    exp_hi  = hi;
    exp_tag = tag;
  endtask

  // invalid cycles carry a LO code so an ignored sample_valid would disturb the FSM
  task automatic run_results(input int n, input int budget, input int div, input string tag);
    int target;
    int k;
    target = n_results + n;
    k = 0;
    while (n_results < target && k < budget) begin
      for (int j = 0; j < div - 1; j++) step(1'b0, 0, 1'b0);
      feed(1);
      k++;
    end
    check(tag, n_results >= target, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_period_sum"}, longint'(bus.period_sum), 0);
    check({tag, "_period_valid"}, longint'(bus.period_valid), 0);
    check({tag, "_locked"}, longint'(bus.locked), 0);
    check({tag, "_no_signal"}, longint'(bus.no_signal), 1);
  endtask

  initial begin
    int t0;
    int k;
    bus.sample_valid = 1'b0;
    bus.sample       = 8'd0;

    do_reset();
    do_reset();
    check_reset_outputs("reset");

    // step 1: 256-sample period, first sum after five crossings
    step_sz = 1;
    set_exp(1024, 1024, "s1_sum");
    run_results(1, 2000, 1, "s1_budget");

    // reset mid-measurement, then five fresh crossings
    feed(600);
    step(1'b1, sinlt(phase), 1'b1);
    phase = (phase + step_sz) % 256;
    check_reset_outputs("midrun_reset");
    run_results(1, 2000, 1, "s6_budget");

    // step 2, then step 4
    do_reset();
    step_sz = 2;
    set_exp(512, 512, "s2_step2");
    run_results(2, 1500, 1, "s2_budget");
    step_sz = 4;
    set_exp(0, 262143, "s2_transition");
    run_results(1, 800, 1, "s2_trans_budget");
    set_exp(256, 256, "s2_step4");
    run_results(1, 500, 1, "s2_step4_budget");

    // step 1 with a qualified sample every third clock
    do_reset();
    step_sz = 1;
    set_exp(1024, 1024, "s3_sum");
    run_results(1, 2000, 3, "s3_budget");
    t0 = int'(last_result_cyc);
    run_results(1, 1100, 3, "s3_budget2");
    check("s3_spacing", last_result_cyc - t0, 3072);

    // step 3: non-integer period
    do_reset();
    step_sz = 3;
    set_exp(341, 342, "s4_sum");
    running_total = 0;
    run_results(3, 1500, 1, "s4_budget");
    check("s4_total_near_1024", (running_total >= 1023 && running_total <= 1025), 1);

    // square wave on the exact thresholds: 119 is LO, 136 is HI, period 10
    do_reset();
    set_exp(40, 40, "threshold_square");
    for (int c = 0; c < 6; c++) begin
      for (int j = 0; j < 5; j++) step(1'b1, 119, 1'b0);
      for (int j = 0; j < 5; j++) step(1'b1, 136, 1'b0);
    end
    check("threshold_results", n_results > 0, 1);

    // lock, then dither inside the band until the timeout
    do_reset();
    step_sz = 1;
    set_exp(1024, 1024, "s5_sum");
    run_results(1, 2000, 1, "s5_budget");
    k = 0;
    while (mstate != 1 && k < 300) begin
      feed(1);
      k++;
    end
    check("s5_reached_low", mstate, 1);
    k = 0;
    while (mcnt < 65534 && k < 70000) begin
      step(1'b1, (k % 2 == 0) ? 124 : 132, 1'b0);
      k++;
    end
    check("s5_before_timeout_no_signal", longint'(bus.no_signal), 0);
    check("s5_before_timeout_locked", longint'(bus.locked), 1);
    step(1'b1, 124, 1'b0);
    check("s5_timeout_no_signal", longint'(bus.no_signal), 1);
    check("s5_timeout_locked", longint'(bus.locked), 0);
    check("s5_period_sum_held", longint'(bus.period_sum), 1024);
    for (int j = 0; j < 8; j++) step(1'b1, (j % 2 == 0) ? 132 : 124, 1'b0);
    check("s5_still_no_signal", longint'(bus.no_signal), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
